multiplicador_seq: RTL and testbench
====================================

# multiplicador_seq

Parametrised sequential shift-add multiplier for the scale datapath: computes price = net weight × price-per-kilo, optionally right-shifted for fixed-point scaling, with saturation and an overflow flag. It replaces the single-cycle combinational multiplier between the tare-subtraction stage and the price display/encoder. A start/busy/done handshake is used so that wider operands do not lengthen the critical path.

## Interface
- W_PESO, 12, width of net weight operand (quilos_tara); also the iteration count
- W_PKG, 10, width of price-per-kilo operand (eurosporquilo)
- W_PRECO, 10, width of price result
- SHIFT, 0, right shift applied to the full product before saturation (fixed-point scaling, truncating)

- clk  input  1  system clock; all state changes on rising edge
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- quilos_tara  input  W_PESO  net weight, unsigned; captured on accepted start
- eurosporquilo  input  W_PKG  price per kilo, unsigned; captured on accepted start
- busy  output  1  high while a multiplication is in progress
- done  output  1  one-cycle pulse: preco/overflow updated
- preco  output  W_PRECO  saturated result; held until next done
- overflow  output  1  shifted product exceeded 2^W_PRECO−1; held with preco

## Operation
- States: IDLE, CALC. Reset → IDLE; busy=0, done=0, preco=0, overflow=0, accumulator/counter cleared.
- IDLE: if start=1 at an edge, capture both operands, clear accumulator (width W_PESO+W_PKG), set counter=0, busy←1, go CALC. Otherwise hold.
- CALC: each edge processes weight bit [counter], LSB first. If the bit is 1, add (eurosporquilo_reg << counter) to the accumulator. Then counter+1.
- At the edge with counter = W_PESO−1, form the final sum p and r = p >> SHIFT. preco ← (r > 2^W_PRECO−1) ? all-ones : r[W_PRECO−1:0], overflow ← (r > 2^W_PRECO−1), done ← 1, busy ← 0, go IDLE.
- Arithmetic is unsigned. The accumulator never overflows internally (full W_PESO+W_PKG bits). Shift truncates and does not round.
- start while busy=1 is ignored. No queuing occurs and captured operands do not change.
- Operand inputs may change freely after capture with no effect.
- Reset has priority over everything, including mid-CALC. The operation is abandoned, no done is issued, and all outputs return to reset values.
- done is cleared on the edge after it is asserted. It never stays high for two consecutive cycles.

## Timing
- Start sampled at edge E0. busy is high from after E0 until after E_W_PESO. done and the new preco/overflow are visible after edge E_W_PESO, which is W_PESO cycles after acceptance (12 with defaults).
- The cycle in which done=1 has busy=0. A start in that cycle is accepted, giving back-to-back issue every W_PESO+1 cycles.
- preco/overflow change only on done edges or on reset.
- Critical path: one W_PESO+W_PKG adder plus saturation compare (final edge only).

## Test plan
- Defaults: quilos_tara=25, eurosporquilo=10, start pulse → done exactly 12 cycles later, preco=250, overflow=0, busy high for 12 cycles.
- Defaults: 100 × 20 (2000) → preco=1023, overflow=1. Next op 3 × 7 → preco=21, overflow=0.
- Defaults: 0 × 1023 and 4095 × 0 → preco=0, overflow=0. 4095 × 1023 → preco=1023, overflow=1.
- Run 25 × 10. At cycle 5 pulse start with 50 × 50 → ignored. Result 250. Single done pulse.
- Run 25 × 10. Assert reset at cycle 6 → busy=0, no done, preco=0 next cycle. Start 2 × 3 afterwards → preco=6.
- SHIFT=3 instance: 500 × 9 (4500) → preco=562, overflow=0. Back-to-back start in done cycle with 1 × 7 → preco=0 (7>>3) after 12 more cycles.

Source files
------------

// File: rtl/multiplicador_seq_if.sv
// Handshake and operand/result bundle for the sequential price multiplier.
// master drives start and operands; slave returns busy/done and the result.
interface multiplicador_seq_if #(
    parameter int W_PESO  = 12,
    parameter int W_PKG   = 10,
    parameter int W_PRECO = 10
);
    logic               start;
    logic [W_PESO-1:0]  quilos_tara;
    logic [W_PKG-1:0]   eurosporquilo;
    logic               busy;
    logic               done;
    logic [W_PRECO-1:0] preco;
    logic               overflow;

    modport master (
        output start, quilos_tara, eurosporquilo,
        input  busy, done, preco, overflow
    );

    modport slave (
        input  start, quilos_tara, eurosporquilo,
        output busy, done, preco, overflow
    );
endinterface

// File: rtl/multiplicador_seq.sv
// Shift-add multiplier: price = weight x price-per-kilo, one weight bit per
// cycle, with truncating fixed-point shift and saturation on the last step.
module multiplicador_seq #(
    parameter int W_PESO  = 12,
    parameter int W_PKG   = 10,
    parameter int W_PRECO = 10,
    parameter int SHIFT   = 0
) (
    input  logic clk,
    input  logic reset,
    multiplicador_seq_if.slave bus
);
    localparam int AW = W_PESO + W_PKG;
    localparam int CW = (W_PESO > 1) ? $clog2(W_PESO) : 1;

    typedef enum logic {IDLE, CALC} state_t;

    state_t             state_q;
    logic [W_PESO-1:0]  peso_q;
    logic [W_PKG-1:0]   pkg_q;
    logic [AW-1:0]      acc_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;
    logic               done_q;
    logic               ovf_q;
    logic [W_PRECO-1:0] preco_q;

    logic [AW-1:0]      addend_d;
    logic [AW-1:0]      acc_d;
    logic [AW-1:0]      res_d;
    logic               ovf_d;
    logic [W_PRECO-1:0] preco_d;
    logic               last_d;

    always_comb begin
        addend_d = peso_q[cnt_q] ? (AW'(pkg_q) << cnt_q) : '0;
        acc_d    = acc_q + addend_d;
        res_d    = acc_d >> SHIFT;
        // any bit above the result width means the value cannot be shown
        ovf_d    = (res_d >> W_PRECO) != '0;
        preco_d  = ovf_d ? '1 : W_PRECO'(res_d);
        last_d   = (cnt_q == CW'(W_PESO - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            peso_q  <= '0;
            pkg_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
            preco_q <= '0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        peso_q  <= bus.quilos_tara;
                        pkg_q   <= bus.eurosporquilo;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (last_d) begin
                        preco_q <= preco_d;
                        ovf_q   <= ovf_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.preco    = preco_q;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_multiplicador_seq.sv
// Bench for multiplicador_seq: vector table, corner sequences and random
// operands against an arithmetic reference, on SHIFT=0 and SHIFT=3 instances.
module tb_multiplicador_seq;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multiplicador_seq_if #(.W_PESO(12), .W_PKG(10), .W_PRECO(10)) m0 ();
    multiplicador_seq_if #(.W_PESO(12), .W_PKG(10), .W_PRECO(10)) m1 ();

    multiplicador_seq #(.W_PESO(12), .W_PKG(10), .W_PRECO(10), .SHIFT(0))
        dut0 (.clk(clk), .reset(reset), .bus(m0));
    multiplicador_seq #(.W_PESO(12), .W_PKG(10), .W_PRECO(10), .SHIFT(3))
        dut1 (.clk(clk), .reset(reset), .bus(m1));

    typedef struct {
        int a;
        int b;
        int ep;
        int eo;
    } vec_t;

    task automatic check(string nm, longint act, longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model(int a, int b, int sh,
                                  output int p, output int o);
        longint r;
        r = (longint'(a) * longint'(b)) >>> sh;
        o = (r > 1023) ? 1 : 0;
        p = (r > 1023) ? 1023 : int'(r);
    endfunction

    task automatic drive(int sel, bit st, int a, int b);
        if (sel == 0) begin
            m0.start = st;
            m0.quilos_tara = a[11:0];
            m0.eurosporquilo = b[9:0];
        end else begin
            m1.start = st;
            m1.quilos_tara = a[11:0];
            m1.eurosporquilo = b[9:0];
        end
    endtask

    function automatic logic r_busy(int sel);
        return (sel == 0) ? m0.busy : m1.busy;
    endfunction
    function automatic logic r_done(int sel);
        return (sel == 0) ? m0.done : m1.done;
    endfunction
    function automatic int r_preco(int sel);
        return (sel == 0) ? int'(m0.preco) : int'(m1.preco);
    endfunction
    function automatic int r_ovf(int sel);
        return (sel == 0) ? int'(m0.overflow) : int'(m1.overflow);
    endfunction

    // Called on the negedge where start was just raised; returns on the
    // negedge at which done is seen. inj>=0 pulses a stray start mid-run.
    task automatic wait_done(int sel, string nm, int ep, int eo, int inj);
        int lat;
        bit bad;
        @(negedge clk);
        drive(sel, 1'b0, $urandom, $urandom);
        lat = 0;
        bad = 1'b0;
        while (!r_done(sel) && lat < 40) begin
            if (!r_busy(sel)) bad = 1'b1;
            if (lat == inj) drive(sel, 1'b1, 50, 50);
            else drive(sel, 1'b0, $urandom, $urandom);
            @(negedge clk);
            lat++;
        end
        drive(sel, 1'b0, 0, 0);
        check({nm, " latency"}, lat, 12);
        check({nm, " busy low mid-run"}, bad, 0);
        check({nm, " busy in done cycle"}, r_busy(sel), 0);
        check({nm, " preco"}, r_preco(sel), ep);
        check({nm, " overflow"}, r_ovf(sel), eo);
    endtask

    task automatic pulse_end(int sel, string nm);
        @(negedge clk);
        check({nm, " done single pulse"}, r_done(sel), 0);
    endtask

    vec_t tbl[$];
    int p, o, a, b, nd;

    initial begin
        drive(0, 1'b0, 0, 0);
        drive(1, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        check("reset busy", m0.busy, 0);
        check("reset done", m0.done, 0);
        check("reset preco", m0.preco, 0);
        check("reset overflow", m0.overflow, 0);
        check("reset1 preco", m1.preco, 0);
        reset = 1'b0;
        @(negedge clk);

        tbl.push_back('{25, 10, 250, 0});
        tbl.push_back('{100, 20, 1023, 1});
        tbl.push_back('{3, 7, 21, 0});
        tbl.push_back('{0, 1023, 0, 0});
        tbl.push_back('{4095, 0, 0, 0});
        tbl.push_back('{4095, 1023, 1023, 1});
        tbl.push_back('{1023, 1, 1023, 0});
        tbl.push_back('{2, 512, 1023, 1});
        tbl.push_back('{1, 1023, 1023, 0});
        foreach (tbl[i]) begin
            drive(0, 1'b1, tbl[i].a, tbl[i].b);
            wait_done(0, $sformatf("vec%0d", i), tbl[i].ep, tbl[i].eo, -1);
            pulse_end(0, $sformatf("vec%0d", i));
        end

        // stray start while busy must be ignored
        drive(0, 1'b1, 25, 10);
        wait_done(0, "ignore", 250, 0, 4);
        nd = 1;
        repeat (14) begin
            @(negedge clk);
            if (m0.done) nd++;
        end
        check("ignore done count", nd, 1);
        check("ignore held preco", m0.preco, 250);

        // reset mid-calculation abandons the operation
        drive(0, 1'b1, 25, 10);
        @(negedge clk);
        drive(0, 1'b0, 0, 0);
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midreset busy", m0.busy, 0);
        check("midreset done", m0.done, 0);
        check("midreset preco", m0.preco, 0);
        nd = 0;
        repeat (16) begin
            @(negedge clk);
            if (m0.done) nd++;
        end
        check("midreset no done", nd, 0);
        drive(0, 1'b1, 2, 3);
        wait_done(0, "post reset", 6, 0, -1);
        pulse_end(0, "post reset");

        // SHIFT=3 instance with back-to-back issue in the done cycle
        drive(1, 1'b1, 500, 9);
        wait_done(1, "shift3", 562, 0, -1);
        drive(1, 1'b1, 1, 7);
        wait_done(1, "b2b", 0, 0, -1);
        pulse_end(1, "b2b");

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = i % 2;
            if (i % 4 < 2) begin
                a = $urandom_range(0, 4095);
                b = $urandom_range(0, 1023);
            end else begin
                a = $urandom_range(0, 127);
                b = $urandom_range(0, 63);
            end
            model(a, b, (sel == 0) ? 0 : 3, p, o);
            drive(sel, 1'b1, a, b);
            wait_done(sel, $sformatf("rnd%0d %0dx%0d", i, a, b), p, o, -1);
            pulse_end(sel, $sformatf("rnd%0d", i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
